mem_access_master: RTL and testbench
====================================

// Module: mem_access_master
// PURPOSE
//  MEM-stage initiator that turns pipeline load/store ops (lw/lh/lb/sw/sh/sb) into word-aligned
//  requests on a req/ack data-memory bus. Generates byte enables and replicated write lanes.
//  Extracts and sign-extends load data. Stalls the pipeline while a transfer is outstanding.
//  Flags misaligned, out-of-range and timed-out accesses.
// PARAMETERS
//  ADDR_LIMIT  32'h0000_3000  first illegal byte address (3072-word data memory)
//  TIMEOUT     16             max cycles in REQ without m_ack before abort (>=2)
// PORTS
//  clk        in   1   clock, all state on posedge
//  reset      in   1   synchronous, active-high
//  start      in   1   pipeline presents a memory op this cycle
//  op         in   3   0 NONE,1 LW,2 LH,3 LB,4 SW,5 SH,6 SB,7 reserved(=NONE)
//  addr       in   32  byte address
//  wd         in   32  store data (low bits used for sh/sb)
//  pc         in   32  pc of the op, latched for exception reporting
//  busy       out  1   stall request to pipeline
//  done       out  1   1-cycle pulse, transfer completed
//  rd         out  32  load result, valid when done, held until next load done
//  exc        out  1   1-cycle exception pulse
//  exc_code   out  2   0 none,1 misaligned,2 out-of-range,3 timeout; held until next exc
//  exc_pc     out  32  pc of faulting op; held until next exc
//  m_req      out  1   bus request
//  m_we       out  1   1 store, 0 load
//  m_addr     out  32  {addr[31:2],2'b00}
//  m_byteen   out  4   byte lanes written (4'b0000 on loads)
//  m_wdata    out  32  lane-replicated store data
//  m_rdata    in   32  read word from memory, sampled with m_ack
//  m_ack      in   1   responder completion, 1 cycle, only meaningful while m_req=1
// BEHAVIOUR
//  Reset: state IDLE; every output 0, including rd, exc_code, exc_pc and counter.
//  States:
//   IDLE: start && op in 1..6 -> check in priority order: misaligned (W: addr[1:0]!=0;
//    H: addr[0]!=0), then out-of-range (addr>=ADDR_LIMIT).
//    On fail: exc pulse next cycle, code/pc latched, no bus activity, stay IDLE.
//    On pass: latch op/addr/wd/pc -> REQ. op 0/7 ignored.
//   REQ: m_req=1, m_we/m_addr/m_byteen/m_wdata stable from latched values.
//    Timeout counter runs from 0.
//    m_ack=1 -> capture m_rdata, drop m_req, -> DONE.
//    Counter reaches TIMEOUT-1 with no ack -> drop m_req, exc code 3, -> IDLE (no done).
//   DONE: done=1 for one cycle; rd updated that cycle for loads, held for stores -> IDLE.
//  busy = (state!=IDLE) | (start & legal op in IDLE); start while not IDLE is ignored.
//  Latency: start at T -> m_req T+1..A (A = ack cycle) -> done at A+1. Minimum 2 cycles (ack at T+1).
//  Stores:
//   SW: byteen 1111, wdata=wd.
//   SH: byteen addr[1]?1100:0011, wdata={2{wd[15:0]}}.
//   SB: byteen 0001<<addr[1:0], wdata={4{wd[7:0]}}.
//  Loads: LW=rdata.
//   LH = sext(rdata half at addr[1]).
//   LB = sext(rdata byte at addr[1:0]).
//  m_ack outside REQ is ignored. Reset in any state (incl. mid-REQ) returns to IDLE next edge,
//  m_req low, no done/exc emitted.
// TESTING
//  LW 0x10, ack 3 cycles later, rdata 0x8765_4321 -> m_addr 0x10, byteen 0000, done 1 cycle after ack, rd 0x8765_4321.
//  LB 0x13 rdata 0x8012_3456 -> rd 0xFFFF_FF80; LH 0x12 same data -> rd 0xFFFF_8012.
//  SB 0x21 wd 0x0000_00AB -> m_we 1, m_addr 0x20, byteen 0010, m_wdata 0xABAB_ABAB.
//  SH 0x22 wd 0x1234_CDEF -> byteen 1100, m_wdata 0xCDEF_CDEF.
//  LW 0x06 -> exc code 1, exc_pc=pc, m_req never rises.
//  SW 0x3000 -> exc code 2, m_req never rises.
//  LW, no ack -> m_req drops after 16 cycles, exc code 3, done never pulses.
//  Reset mid-REQ -> m_req low and busy 0 next cycle.
//  Start while busy -> ignored.

Source files
------------

// File: rtl/mem_access_master.sv
// MEM-stage bus initiator: turns pipeline load/store ops into word-aligned
// req/ack transfers, builds byte lanes, sign-extends load data, and reports
// misaligned, out-of-range and timed-out accesses.
//
//   state  | meaning
//   IDLE   | no transfer outstanding, accepting new ops
//   REQ    | m_req asserted, waiting for m_ack or timeout
//   DONE   | one-cycle completion pulse, rd valid for loads
module mem_access_master #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000,
    parameter int          TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd,
    output logic        exc,
    output logic [1:0]  exc_code,
    output logic [31:0] exc_pc,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_byteen,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    localparam logic [2:0] OP_LW = 3'd1, OP_LH = 3'd2, OP_LB = 3'd3;
    localparam logic [2:0] OP_SW = 3'd4, OP_SH = 3'd5, OP_SB = 3'd6;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [2:0]    op_q;
    logic [31:0]   addr_q, wd_q, pc_q;
    logic [CW-1:0] cnt;

    logic op_valid, misalign, out_of_range, accept, fault, timeout_hit;

    assign op_valid     = (op != 3'd0) && (op != 3'd7);
    assign misalign     = (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00)) ||
                          (((op == OP_LH) || (op == OP_SH)) && addr[0]);
    assign out_of_range = (addr >= ADDR_LIMIT);
    assign accept       = (state == S_IDLE) && start && op_valid;
    assign fault        = misalign || out_of_range;
    assign timeout_hit  = (state == S_REQ) && !m_ack && (cnt == CW'(TIMEOUT - 1));

    // Pick the addressed half/byte out of the read word and sign-extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] o, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [15:0] h;
        logic [7:0]  b;
        h = a[1] ? w[31:16] : w[15:0];
        b = w[8*a +: 8];
        case (o)
            OP_LH:   return {{16{h[15]}}, h};
            OP_LB:   return {{24{b[7]}}, b};
            default: return w;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; ack wins over a timeout landing in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && !fault) state_nxt = S_REQ;
            S_REQ:   if (m_ack) state_nxt = S_DONE;
                     else if (timeout_hit) state_nxt = S_IDLE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus and handshake outputs; bus fields are only driven while requesting.
    always_comb begin
        m_req    = (state == S_REQ);
        done     = (state == S_DONE);
        busy     = (state != S_IDLE) || accept;
        m_we     = 1'b0;
        m_addr   = 32'h0;
        m_byteen = 4'b0000;
        m_wdata  = 32'h0;
        if (state == S_REQ) begin
            m_addr = {addr_q[31:2], 2'b00};
            case (op_q)
                OP_SW: begin
                    m_we = 1'b1; m_byteen = 4'b1111; m_wdata = wd_q;
                end
                OP_SH: begin
                    m_we = 1'b1; m_byteen = addr_q[1] ? 4'b1100 : 4'b0011;
                    m_wdata = {2{wd_q[15:0]}};
                end
                OP_SB: begin
                    m_we = 1'b1; m_byteen = 4'b0001 << addr_q[1:0];
                    m_wdata = {4{wd_q[7:0]}};
                end
                default: ;
            endcase
        end
    end

    // Operand latch, timeout counter, load result and exception reporting.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= 3'd0;
            addr_q   <= 32'h0;
            wd_q     <= 32'h0;
            pc_q     <= 32'h0;
            cnt      <= '0;
            rd       <= 32'h0;
            exc      <= 1'b0;
            exc_code <= 2'd0;
            exc_pc   <= 32'h0;
        end else begin
            exc <= 1'b0;
            if (accept && fault) begin
                exc      <= 1'b1;
                exc_code <= misalign ? 2'd1 : 2'd2;
                exc_pc   <= pc;
            end else if (accept) begin
                op_q   <= op;
                addr_q <= addr;
                wd_q   <= wd;
                pc_q   <= pc;
            end
            if (state != S_REQ) cnt <= '0;
            else if (!m_ack)    cnt <= cnt + CW'(1);
            if (timeout_hit) begin
                exc      <= 1'b1;
                exc_code <= 2'd3;
                exc_pc   <= pc_q;
            end
            if ((state == S_REQ) && m_ack && (op_q <= OP_LB))
                rd <= load_extract(op_q, addr_q[1:0], m_rdata);
        end
    end

endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: directed cases plus random load/store traffic
// compared against a byte-level reference model.
module tb_mem_access_master;

    localparam logic [31:0] LIMIT = 32'h0000_3000;
    localparam int          TMO   = 16;

    logic        clk = 1'b0;
    logic        reset, start, m_ack;
    logic [2:0]  op;
    logic [31:0] addr, wd, pc, m_rdata;
    logic        busy, done, exc, m_req, m_we;
    logic [31:0] rd, exc_pc, m_addr, m_wdata;
    logic [1:0]  exc_code;
    logic [3:0]  m_byteen;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_model;
    logic [1:0]  code_model;
    logic [31:0] epc_model;

    mem_access_master #(.ADDR_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .wd(wd), .pc(pc),
        .busy(busy), .done(done), .rd(rd), .exc(exc), .exc_code(exc_code), .exc_pc(exc_pc),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_byteen(m_byteen), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int op_size(input logic [2:0] o);
        if (o == 3'd1 || o == 3'd4) return 4;
        if (o == 3'd2 || o == 3'd5) return 2;
        return 1;
    endfunction

    // Load value: gather size bytes little-endian from the word, then sign-extend arithmetically.
    function automatic logic [31:0] model_load(input int size, input logic [31:0] a, input logic [31:0] w);
        longint v;
        int     off;
        v   = 0;
        off = int'(a & 32'h3);
        for (int i = 0; i < size; i++)
            v += longint'((w >> (8 * (off + i))) & 32'hFF) << (8 * i);
        if (v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
        return v[31:0];
    endfunction

    // Lane i is written when its byte address lies inside [a, a+size); it carries wd byte i mod size.
    function automatic logic [35:0] model_store(input int size, input logic [31:0] a, input logic [31:0] w);
        logic [3:0]  en;
        logic [31:0] data;
        longint      base, b;
        en   = 4'b0000;
        data = 32'h0;
        base = longint'(a) - longint'(a % 4);
        for (int i = 0; i < 4; i++) begin
            b = base + i;
            if (b >= longint'(a) && b < longint'(a) + size) en[i] = 1'b1;
            data = data | (((w >> (8 * (i % size))) & 32'hFF) << (8 * i));
        end
        return {en, data};
    endfunction

    // One op through the DUT. ack_wait = REQ cycles before the ack; >= TMO means never ack.
    // stray = issue an extra start while the transfer is outstanding.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                          input logic [31:0] p, input logic [31:0] rdata, input int ack_wait,
                          input bit stray);
        int          size;
        bit          mis, oor, acked, is_store;
        logic [35:0] st;
        size     = op_size(o);
        is_store = (o >= 3'd4);
        mis      = (a % size) != 0;
        oor      = a >= LIMIT;
        st       = model_store(size, a, w);

        @(negedge clk);
        start = 1'b1; op = o; addr = a; wd = w; pc = p;
        #1 chk("busy_on_start", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0; op = 3'd0; addr = $urandom; wd = $urandom; pc = $urandom;
        #1;
        if (mis || oor) begin
            code_model = mis ? 2'd1 : 2'd2;
            epc_model  = p;
            chk("fault_exc", 32'(exc), 32'd1);
            chk("fault_code", 32'(exc_code), 32'(code_model));
            chk("fault_pc", exc_pc, epc_model);
            chk("fault_no_req", 32'(m_req), 32'd0);
            chk("fault_busy", 32'(busy), 32'd0);
            @(negedge clk);
            chk("fault_exc_pulse", 32'(exc), 32'd0);
            chk("fault_no_req2", 32'(m_req), 32'd0);
            return;
        end
        acked = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            chk("req_high", 32'(m_req), 32'd1);
            chk("req_no_exc", 32'(exc), 32'd0);
            chk("req_busy", 32'(busy), 32'd1);
            if (k == 0) begin
                chk("m_we", 32'(m_we), 32'(is_store));
                chk("m_addr", m_addr, a & ~32'h3);
                chk("m_byteen", 32'(m_byteen), is_store ? 32'(st[35:32]) : 32'd0);
                if (is_store) chk("m_wdata", m_wdata, st[31:0]);
            end
            if (stray && k == 1) begin
                start = 1'b1; op = 3'd3; addr = LIMIT + 32'd5; pc = 32'hDEAD_0000;
            end else begin
                start = 1'b0; op = 3'd0;
            end
            m_rdata = $urandom;
            if (k == ack_wait) begin
                m_ack = 1'b1; m_rdata = rdata; acked = 1'b1;
            end
            @(negedge clk);
            start = 1'b0; op = 3'd0;
            m_ack = 1'b0; m_rdata = $urandom;
            #1;
            if (acked) break;
        end
        if (acked) begin
            if (!is_store) rd_model = model_load(size, a, rdata);
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_req_low", 32'(m_req), 32'd0);
            chk("rd", rd, rd_model);
            chk("done_no_exc", 32'(exc), 32'd0);
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("rd_held", rd, rd_model);
        end else begin
            code_model = 2'd3;
            epc_model  = p;
            chk("tmo_req_low", 32'(m_req), 32'd0);
            chk("tmo_exc", 32'(exc), 32'd1);
            chk("tmo_code", 32'(exc_code), 32'd3);
            chk("tmo_pc", exc_pc, epc_model);
            chk("tmo_no_done", 32'(done), 32'd0);
            @(negedge clk);
            chk("tmo_exc_pulse", 32'(exc), 32'd0);
            chk("tmo_no_done2", 32'(done), 32'd0);
            chk("tmo_rd_held", rd, rd_model);
        end
        chk("exc_code_held", 32'(exc_code), 32'(code_model));
    endtask

    initial begin
        int          o_r, aw;
        logic [31:0] a_r;

        reset = 1'b1; start = 1'b0; op = 3'd0; addr = 32'h0; wd = 32'h0; pc = 32'h0;
        m_rdata = 32'h0; m_ack = 1'b0;
        rd_model = 32'h0; code_model = 2'd0; epc_model = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(m_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd", rd, 32'h0);
        chk("rst_exc", 32'(exc), 32'd0);
        chk("rst_code", 32'(exc_code), 32'd0);
        chk("rst_epc", exc_pc, 32'h0);
        chk("rst_byteen", 32'(m_byteen), 32'd0);
        reset = 1'b0;

        // Directed cases
        run_op(3'd1, 32'h10, 32'h0, 32'h100, 32'h8765_4321, 2, 1'b0);
        run_op(3'd3, 32'h13, 32'h0, 32'h104, 32'h8012_3456, 0, 1'b0);
        chk("lb_value", rd, 32'hFFFF_FF80);
        run_op(3'd2, 32'h12, 32'h0, 32'h108, 32'h8012_3456, 1, 1'b0);
        chk("lh_value", rd, 32'hFFFF_8012);
        run_op(3'd6, 32'h21, 32'h0000_00AB, 32'h10C, 32'h0, 0, 1'b0);
        run_op(3'd5, 32'h22, 32'h1234_CDEF, 32'h110, 32'h0, 3, 1'b0);
        chk("rd_kept_after_store", rd, 32'hFFFF_8012);
        run_op(3'd1, 32'h06, 32'h0, 32'h114, 32'h0, 0, 1'b0);
        run_op(3'd4, 32'h3000, 32'h0, 32'h118, 32'h0, 0, 1'b0);
        run_op(3'd1, 32'h3002, 32'h0, 32'h11C, 32'h0, 0, 1'b0);
        run_op(3'd3, 32'h2FFF, 32'h0, 32'h120, 32'h7F00_0000, 0, 1'b0);
        run_op(3'd1, 32'h40, 32'h0, 32'h124, 32'h0, TMO, 1'b1);
        run_op(3'd4, 32'h44, 32'hCAFE_F00D, 32'h128, 32'h0, TMO - 1, 1'b0);

        // op NONE/reserved and a stray ack in IDLE must do nothing
        @(negedge clk);
        start = 1'b1; op = 3'd7; addr = 32'h3; m_ack = 1'b1; m_rdata = 32'h1111_1111;
        #1 chk("reserved_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0; op = 3'd0; m_ack = 1'b0;
        #1;
        chk("reserved_no_req", 32'(m_req), 32'd0);
        chk("reserved_no_exc", 32'(exc), 32'd0);
        chk("idle_ack_no_done", 32'(done), 32'd0);
        chk("idle_ack_rd", rd, rd_model);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            o_r = $urandom_range(1, 6);
            a_r = ($urandom_range(0, 7) == 0) ? 32'h2FF8 + $urandom_range(0, 15)
                                               : 32'($urandom_range(0, 32'h2FFF));
            aw  = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 5);
            run_op(3'(o_r), a_r, $urandom, $urandom, $urandom, aw, n[2]);
        end

        // Reset while a request is outstanding
        @(negedge clk);
        start = 1'b1; op = 3'd1; addr = 32'h80; pc = 32'h200;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        #1 chk("pre_rst_req", 32'(m_req), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_req", 32'(m_req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_exc", 32'(exc), 32'd0);
        chk("midrst_rd", rd, 32'h0);
        reset = 1'b0;
        rd_model = 32'h0; code_model = 2'd0;
        @(negedge clk);
        chk("postrst_req", 32'(m_req), 32'd0);
        chk("postrst_code", 32'(exc_code), 32'd0);
        run_op(3'd2, 32'h82, 32'h0, 32'h204, 32'h0000_7FFF, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
